// File: rtl/flow_queue_bank_pkg.sv
// Shared defaults and helpers for the per-flow queue bank ahead of the DWRR arbiter.
package qbank_pkg;
  localparam int NUM_REQS_D = 4;
  localparam int DWID_D     = 8;
  localparam int DEPTH_D    = 4;
  localparam int PTRW_D     = $clog2(DEPTH_D);
  localparam int CNT_W_D    = PTRW_D + 1;
  localparam int CNTWID_D   = $clog2(NUM_REQS_D);
  localparam int VEC_MAX    = 32;

  // True when at most one bit is set; callers zero-extend narrower vectors.
  function automatic logic onehot0(input logic [VEC_MAX-1:0] vec);
    return (vec & (vec - VEC_MAX'(1))) == '0;
  endfunction
endpackage

// File: rtl/flow_queue_bank_if.sv
// Ingress, arbiter and egress bundle for flow_queue_bank.
interface flow_queue_bank_if import qbank_pkg::*; #(
  parameter int NUM_REQS = NUM_REQS_D,
  parameter int DWID     = DWID_D,
  parameter int CNTWID   = CNTWID_D
);
  logic                in_valid;
  logic [CNTWID-1:0]   in_flow;
  logic [DWID-1:0]     in_data;
  logic                in_ready;
  logic [NUM_REQS-1:0] reqs;
  logic [NUM_REQS-1:0] gnt;
  logic                out_valid;
  logic [CNTWID-1:0]   out_flow;
  logic [DWID-1:0]     out_data;
  logic                gnt_err;

  modport slave  (input  in_valid, in_flow, in_data, gnt,
                  output in_ready, reqs, out_valid, out_flow, out_data, gnt_err);
  modport master (output in_valid, in_flow, in_data, gnt,
                  input  in_ready, reqs, out_valid, out_flow, out_data, gnt_err);
endinterface

// File: rtl/flow_queue_bank_fifo.sv
// One circular FIFO per flow; storage is not reset, only pointers and count.
module flow_fifo #(
  parameter int DWID  = 8,
  parameter int DEPTH = 4,
  parameter int PTRW  = $clog2(DEPTH)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [DWID-1:0] din,
  output logic [DWID-1:0] dout,
  output logic            empty,
  output logic            full
);
  logic [DWID-1:0] mem [DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [PTRW:0]   count;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTRW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTRW+1)'(1);
        2'b01:   count <= count - (PTRW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/flow_queue_bank.sv
// Per-flow packet buffering in front of the DWRR arbiter: push by in_flow, pop by one-hot gnt.
module flow_queue_bank import qbank_pkg::*; #(
  parameter int NUM_REQS = NUM_REQS_D,
  parameter int DWID     = DWID_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int PTRW     = $clog2(DEPTH),
  parameter int CNTWID   = $clog2(NUM_REQS)
)(
  input  logic               clk,
  input  logic               rst,
  flow_queue_bank_if.slave   bus
);
  logic [NUM_REQS-1:0]           push, pop, empty, full;
  logic [NUM_REQS-1:0][DWID-1:0] dout;
  logic                          gnt_bad;
  logic [CNTWID-1:0]             pop_idx;
  logic [DWID-1:0]               pop_data;
  logic                          out_valid_q, gnt_err_q;
  logic [CNTWID-1:0]             out_flow_q;
  logic [DWID-1:0]               out_data_q;

  assign bus.in_ready = ~full[bus.in_flow];
  assign bus.reqs     = ~empty;

  // A malformed grant pops nothing at all, even if one of its bits is legal.
  assign gnt_bad = !onehot0(VEC_MAX'(bus.gnt)) || (|(bus.gnt & empty));
  assign pop     = gnt_bad ? '0 : bus.gnt;

  always_comb begin
    pop_idx  = '0;
    pop_data = '0;
    for (int i = 0; i < NUM_REQS; i++)
      if (pop[i]) begin
        pop_idx  = CNTWID'(i);
        pop_data = dout[i];
      end
  end

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_q
    assign push[gi] = bus.in_valid & bus.in_ready & (bus.in_flow == CNTWID'(gi));
    flow_fifo #(.DWID(DWID), .DEPTH(DEPTH), .PTRW(PTRW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[gi]),
      .pop   (pop[gi]),
      .din   (bus.in_data),
      .dout  (dout[gi]),
      .empty (empty[gi]),
      .full  (full[gi])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_flow_q  <= '0;
      out_data_q  <= '0;
      gnt_err_q   <= 1'b0;
    end else begin
      out_valid_q <= |pop;
      if (|pop) begin
        out_flow_q <= pop_idx;
        out_data_q <= pop_data;
      end
      gnt_err_q <= gnt_err_q | gnt_bad;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_flow  = out_flow_q;
  assign bus.out_data  = out_data_q;
  assign bus.gnt_err   = gnt_err_q;
endmodule

// File: tb/tb_flow_queue_bank.sv
// Directed vector bench for flow_queue_bank (NUM_REQS=4, DWID=8, DEPTH=4).
module tb_flow_queue_bank;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  flow_queue_bank_if bus ();
  flow_queue_bank dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [1:0] fl;
    logic [7:0] d;
    logic [3:0] g;
    logic       rdy;
    logic [3:0] rq;
    logic       ov;
    logic [1:0] of;
    logic [7:0] od;
    logic       er;
  } vec_t;

  vec_t tv [35];

  function automatic vec_t mk(input logic iv, input logic [1:0] fl, input logic [7:0] d,
                              input logic [3:0] g, input logic rdy, input logic [3:0] rq,
                              input logic ov, input logic [1:0] of, input logic [7:0] od,
                              input logic er);
    vec_t v;
    v.iv = iv; v.fl = fl; v.d = d; v.g = g; v.rdy = rdy;
    v.rq = rq; v.ov = ov; v.of = of; v.od = od; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic [3:0] rq, input logic ov,
                         input logic [1:0] of, input logic [7:0] od, input logic er);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(rdy));
    chk({tag, ".reqs"},      32'(bus.reqs),      32'(rq));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".out_flow"},  32'(bus.out_flow),  32'(of));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(od));
    chk({tag, ".gnt_err"},   32'(bus.gnt_err),   32'(er));
  endtask

  task automatic drive(input logic iv, input logic [1:0] fl, input logic [7:0] d, input logic [3:0] g);
    bus.in_valid = iv;
    bus.in_flow  = fl;
    bus.in_data  = d;
    bus.gnt      = g;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Each vector: inputs applied at negedge; outputs reflect state after the previous edges.
    //             iv fl  data   gnt     rdy rq     ov of  od     er
    tv[0]  = mk(1, 2, 8'hA1, 4'h0,  1, 4'h0, 0, 0, 8'h00, 0);
    tv[1]  = mk(1, 2, 8'hA2, 4'h0,  1, 4'h4, 0, 0, 8'h00, 0);
    tv[2]  = mk(0, 0, 8'h00, 4'h4,  1, 4'h4, 0, 0, 8'h00, 0);
    tv[3]  = mk(0, 0, 8'h00, 4'h4,  1, 4'h4, 1, 2, 8'hA1, 0);
    tv[4]  = mk(0, 0, 8'h00, 4'h0,  1, 4'h0, 1, 2, 8'hA2, 0);
    tv[5]  = mk(0, 0, 8'h00, 4'h0,  1, 4'h0, 0, 2, 8'hA2, 0);
    tv[6]  = mk(1, 1, 8'hB1, 4'h0,  1, 4'h0, 0, 2, 8'hA2, 0);
    tv[7]  = mk(1, 1, 8'hB2, 4'h0,  1, 4'h2, 0, 2, 8'hA2, 0);
    tv[8]  = mk(1, 1, 8'hB3, 4'h0,  1, 4'h2, 0, 2, 8'hA2, 0);
    tv[9]  = mk(1, 1, 8'hB4, 4'h0,  1, 4'h2, 0, 2, 8'hA2, 0);
    tv[10] = mk(1, 1, 8'hB5, 4'h0,  0, 4'h2, 0, 2, 8'hA2, 0);
    tv[11] = mk(1, 0, 8'hC1, 4'h0,  1, 4'h2, 0, 2, 8'hA2, 0);
    tv[12] = mk(1, 1, 8'hB6, 4'h2,  0, 4'h3, 0, 2, 8'hA2, 0);
    tv[13] = mk(0, 1, 8'h00, 4'h0,  1, 4'h3, 1, 1, 8'hB1, 0);
    tv[14] = mk(0, 0, 8'h00, 4'h2,  1, 4'h3, 0, 1, 8'hB1, 0);
    tv[15] = mk(0, 0, 8'h00, 4'h2,  1, 4'h3, 1, 1, 8'hB2, 0);
    tv[16] = mk(0, 0, 8'h00, 4'h2,  1, 4'h3, 1, 1, 8'hB3, 0);
    tv[17] = mk(0, 0, 8'h00, 4'h1,  1, 4'h1, 1, 1, 8'hB4, 0);
    tv[18] = mk(0, 0, 8'h00, 4'h0,  1, 4'h0, 1, 0, 8'hC1, 0);
    tv[19] = mk(1, 3, 8'hD1, 4'h0,  1, 4'h0, 0, 0, 8'hC1, 0);
    tv[20] = mk(1, 3, 8'hD2, 4'h8,  1, 4'h8, 0, 0, 8'hC1, 0);
    tv[21] = mk(1, 3, 8'hD3, 4'h8,  1, 4'h8, 1, 3, 8'hD1, 0);
    tv[22] = mk(1, 3, 8'hD4, 4'h8,  1, 4'h8, 1, 3, 8'hD2, 0);
    tv[23] = mk(1, 3, 8'hD5, 4'h8,  1, 4'h8, 1, 3, 8'hD3, 0);
    tv[24] = mk(1, 3, 8'hD6, 4'h8,  1, 4'h8, 1, 3, 8'hD4, 0);
    tv[25] = mk(0, 0, 8'h00, 4'h8,  1, 4'h8, 1, 3, 8'hD5, 0);
    tv[26] = mk(0, 0, 8'h00, 4'h0,  1, 4'h0, 1, 3, 8'hD6, 0);
    tv[27] = mk(1, 0, 8'hE1, 4'h0,  1, 4'h0, 0, 3, 8'hD6, 0);
    tv[28] = mk(1, 1, 8'hF1, 4'h0,  1, 4'h1, 0, 3, 8'hD6, 0);
    tv[29] = mk(0, 0, 8'h00, 4'h3,  1, 4'h3, 0, 3, 8'hD6, 0);
    tv[30] = mk(0, 0, 8'h00, 4'h4,  1, 4'h3, 0, 3, 8'hD6, 1);
    tv[31] = mk(0, 0, 8'h00, 4'h1,  1, 4'h3, 0, 3, 8'hD6, 1);
    tv[32] = mk(0, 0, 8'h00, 4'h2,  1, 4'h2, 1, 0, 8'hE1, 1);
    tv[33] = mk(0, 0, 8'h00, 4'h0,  1, 4'h0, 1, 1, 8'hF1, 1);
    tv[34] = mk(0, 0, 8'h00, 4'h0,  1, 4'h0, 0, 1, 8'hF1, 1);

    // Reset held with random inputs.
    rst = 1'b0;
    drive(0, 0, 8'h00, 4'h0);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      drive(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));
      #2;
      chk_all($sformatf("rst%0d", r), 1, 4'h0, 0, 0, 8'h00, 0);
    end
    drive(0, 0, 8'h00, 4'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      drive(tv[i].iv, tv[i].fl, tv[i].d, tv[i].g);
      #2;
      chk_all($sformatf("v%0d", i), tv[i].rdy, tv[i].rq, tv[i].ov, tv[i].of, tv[i].od, tv[i].er);
    end

    // Async reset mid-burst: flow 2 holds a second packet that must never egress.
    @(negedge clk); drive(1, 2, 8'h61, 4'h0);
    @(negedge clk); drive(1, 2, 8'h62, 4'h0);
    @(negedge clk); drive(0, 2, 8'h00, 4'h4);
    @(negedge clk); drive(0, 2, 8'h00, 4'h4);
    #2;
    chk_all("pre_rst", 1, 4'h4, 1, 2, 8'h61, 1);
    #1 rst = 1'b0;
    #1;
    chk_all("async_rst", 1, 4'h0, 0, 0, 8'h00, 0);
    @(negedge clk);
    #2;
    chk_all("rst_hold", 1, 4'h0, 0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 4'h0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      chk_all($sformatf("post_rst%0d", k), 1, 4'h0, 0, 0, 8'h00, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
